// File: rtl/sobel.sv
// Streaming 3x3 Sobel edge detector for a fixed 256x256 8-bit image.
// Pixels arrive in raster order; the magnitude of each complete window is presented combinationally.
module sobel (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Start,
   input  logic [7:0] DataIn,
   input  logic [7:0] Threshold,
   output logic       Finish,
   output logic       isReady,
   output logic       Dop,
   output logic [7:0] Gradient,
   output logic [1:0] debug_current_state,
   output logic [7:0] debug_Out_Row,
   output logic [7:0] debug_Out_Column
);

   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  LOAD      = 2'd1;
   localparam logic [1:0]  COMPUTE   = 2'd2;
   localparam logic [1:0]  DONE      = 2'd3;
   localparam logic [16:0] FIRST_WIN = 17'd514;
   localparam logic [16:0] FRAME_PIX = 17'd65536;

   logic [1:0]  state;
   logic [16:0] pix_cnt;
   logic [7:0]  new_row;
   logic [7:0]  new_col;
   logic [7:0]  lb1 [256];
   logic [7:0]  lb2 [256];
   logic [7:0]  w_top [3];
   logic [7:0]  w_mid [3];
   logic [7:0]  w_bot [3];
   logic        take;
   logic [7:0]  wr_col;

   // A pixel is consumed on every LOAD/COMPUTE edge until the whole frame is in.
   assign take   = ((state == LOAD) || (state == COMPUTE)) && !pix_cnt[16];
   assign wr_col = pix_cnt[7:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         pix_cnt <= '0;
         new_row <= '0;
         new_col <= '0;
         for (int i = 0; i < 3; i++) begin
            w_top[i] <= '0;
            w_mid[i] <= '0;
            w_bot[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state   <= LOAD;
                  pix_cnt <= '0;
               end
            end
            LOAD: begin
               if (pix_cnt == FIRST_WIN) state <= COMPUTE;
            end
            COMPUTE: begin
               // pix_cnt reaching FRAME_PIX marks the flush cycle
               if (pix_cnt == FRAME_PIX) state <= DONE;
            end
            default: begin
               if (!Start) state <= IDLE;
            end
         endcase
         if (take) begin
            pix_cnt  <= pix_cnt + 17'd1;
            new_row  <= pix_cnt[15:8];
            new_col  <= pix_cnt[7:0];
            w_top[0] <= w_top[1];
            w_top[1] <= w_top[2];
            w_top[2] <= lb2[wr_col];
            w_mid[0] <= w_mid[1];
            w_mid[1] <= w_mid[2];
            w_mid[2] <= lb1[wr_col];
            w_bot[0] <= w_bot[1];
            w_bot[1] <= w_bot[2];
            w_bot[2] <= DataIn;
         end
      end
   end

   // lb1 holds the previous row, lb2 the row above it; contents survive reset.
   always_ff @(posedge CLK) begin
      if (take) begin
         lb2[wr_col] <= lb1[wr_col];
         lb1[wr_col] <= DataIn;
      end
   end

   logic [11:0] gx_pos, gx_neg, gy_pos, gy_neg;
   logic [11:0] ax, ay, mag;
   logic [7:0]  sat;
   logic        valid;

   always_comb begin
      gx_pos = {4'b0, w_top[2]} + {3'b0, w_mid[2], 1'b0} + {4'b0, w_bot[2]};
      gx_neg = {4'b0, w_top[0]} + {3'b0, w_mid[0], 1'b0} + {4'b0, w_bot[0]};
      gy_pos = {4'b0, w_bot[0]} + {3'b0, w_bot[1], 1'b0} + {4'b0, w_bot[2]};
      gy_neg = {4'b0, w_top[0]} + {3'b0, w_top[1], 1'b0} + {4'b0, w_top[2]};
      ax     = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
      ay     = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
      mag    = ax + ay;
      sat    = (mag > 12'd255) ? 8'hFF : mag[7:0];
   end

   // Windows whose newest column is 0 or 1 straddle a row wrap and are suppressed.
   assign valid               = (state == COMPUTE) && (new_col >= 8'd2);
   assign isReady             = valid;
   assign Gradient            = valid ? sat : 8'd0;
   assign Dop                 = valid && (sat > Threshold);
   assign debug_Out_Row       = valid ? (new_row - 8'd1) : 8'd0;
   assign debug_Out_Column    = valid ? (new_col - 8'd1) : 8'd0;
   assign Finish              = (state == IDLE) || (state == DONE);
   assign debug_current_state = state;

endmodule

// File: tb/tb_sobel.sv
// Bench for sobel: one aborted frame (reset mid-COMPUTE) then a full frame checked
// cycle by cycle against a frame-level model of states, validity and gradients.
module tb_sobel;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Start = 1'b0;
   logic [7:0] DataIn = 8'd0;
   logic [7:0] Threshold = 8'd0;
   logic       Finish, isReady, Dop;
   logic [7:0] Gradient;
   logic [1:0] debug_current_state;
   logic [7:0] debug_Out_Row, debug_Out_Column;

   sobel dut (
      .CLK(CLK), .RST(RST), .Start(Start), .DataIn(DataIn), .Threshold(Threshold),
      .Finish(Finish), .isReady(isReady), .Dop(Dop), .Gradient(Gradient),
      .debug_current_state(debug_current_state),
      .debug_Out_Row(debug_Out_Row), .debug_Out_Column(debug_Out_Column)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int frame_j = -1;
   int ready_cnt = 0;
   logic [7:0] img [65536];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int px(input int r, input int c);
      return int'(img[r*256 + c]);
   endfunction

   function automatic int model_grad(input int cr, input int cc);
      int gx, gy, s;
      gx = (px(cr-1, cc+1) + 2*px(cr, cc+1) + px(cr+1, cc+1))
         - (px(cr-1, cc-1) + 2*px(cr, cc-1) + px(cr+1, cc-1));
      gy = (px(cr+1, cc-1) + 2*px(cr+1, cc) + px(cr+1, cc+1))
         - (px(cr-1, cc-1) + 2*px(cr-1, cc) + px(cr-1, cc+1));
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (s > 255) ? 255 : s;
   endfunction

   // frame_j = rising edges since the edge that accepted Start
   always @(negedge CLK) begin
      if (frame_j >= 0) begin
         int n, r, c, es, er, eg, ed, erow, ecol;
         if (frame_j < 515)        es = 1;
         else if (frame_j <= 65536) es = 2;
         else if (frame_j <= 65540) es = 3;
         else                       es = 0;
         er = 0; eg = 0; ed = 0; erow = 0; ecol = 0;
         if (es == 2) begin
            n = frame_j - 1;
            r = n / 256;
            c = n % 256;
            if (c >= 2) begin
               er   = 1;
               erow = r - 1;
               ecol = c - 1;
               eg   = model_grad(erow, ecol);
               ed   = (eg > int'(Threshold)) ? 1 : 0;
            end
         end
         check("state", int'(debug_current_state), es);
         check("finish", int'(Finish), (es == 0 || es == 3) ? 1 : 0);
         check("is_ready", int'(isReady), er);
         check("gradient", int'(Gradient), eg);
         check("dop", int'(Dop), ed);
         check("out_row", int'(debug_Out_Row), erow);
         check("out_col", int'(debug_Out_Column), ecol);
         if (isReady) ready_cnt++;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_state"}, int'(debug_current_state), 0);
      check({tag, "_finish"}, int'(Finish), 1);
      check({tag, "_ready"}, int'(isReady), 0);
      check({tag, "_dop"}, int'(Dop), 0);
      check({tag, "_grad"}, int'(Gradient), 0);
      check({tag, "_row"}, int'(debug_Out_Row), 0);
      check({tag, "_col"}, int'(debug_Out_Column), 0);
   endtask

   task automatic run_frame(input int stop_at);
      Start  = 1'b1;
      DataIn = 8'($urandom_range(0, 255));
      @(posedge CLK);
      #1 frame_j = 0;
      for (int j = 0; j < 65541; j++) begin
         if (stop_at > 0 && j == stop_at) begin
            @(negedge CLK);
            #1 frame_j = -1;
            RST   = 1'b1;
            Start = 1'b1;
            @(posedge CLK);
            #1 check_idle("mid_reset");
            @(posedge CLK);
            #1 check_idle("reset_hold");
            RST   = 1'b0;
            Start = 1'b0;
            @(posedge CLK);
            #1 check_idle("after_reset");
            return;
         end
         DataIn    = (j < 65536) ? img[j] : 8'($urandom_range(0, 255));
         Start     = (j < 65536) ? 1'($urandom_range(0, 1)) : (j < 65540);
         Threshold = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(5, 10));
         @(posedge CLK);
         #1 frame_j = j + 1;
         if (j + 1 == 515) begin
            check("first_row", int'(debug_Out_Row), 1);
            check("first_col", int'(debug_Out_Column), 1);
         end
         if (j + 1 == 65536) begin
            check("last_row", int'(debug_Out_Row), 254);
            check("last_col", int'(debug_Out_Column), 254);
         end
      end
      @(negedge CLK);
      #1 frame_j = -1;
   endtask

   initial begin
      // bands: uniform 50, vertical step at col 128, ramp pixel=col, random
      for (int r = 0; r < 256; r++) begin
         for (int c = 0; c < 256; c++) begin
            if (r < 64)       img[r*256 + c] = 8'd50;
            else if (r < 128) img[r*256 + c] = (c < 128) ? 8'd0 : 8'd100;
            else if (r < 192) img[r*256 + c] = 8'(c);
            else              img[r*256 + c] = 8'($urandom_range(0, 255));
         end
      end
      check("model_uniform", model_grad(30, 30), 0);
      check("model_step_127", model_grad(100, 127), 255);
      check("model_step_128", model_grad(100, 128), 255);
      check("model_step_126", model_grad(100, 126), 0);
      check("model_ramp", model_grad(150, 50), 8);
      check("model_ramp_edge", model_grad(150, 254), 8);

      RST   = 1'b1;
      Start = 1'b1;
      repeat (3) @(posedge CLK);
      #1 check_idle("reset");
      RST   = 1'b0;
      Start = 1'b0;
      @(posedge CLK);
      #1 check_idle("idle");

      run_frame(1000);

      ready_cnt = 0;
      run_frame(0);
      check("ready_count", ready_cnt, 64516);
      @(posedge CLK);
      #1 check_idle("end_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel.md
SOBEL -- requirements
Module: sobel

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock; RST  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: Start in 1 begin request; DataIn in 8 pixel stream; Threshold in 8 edge threshold.
REQ-003 SHALL have ports: Finish out 1 (1 = idle/done, 0 = busy); isReady out 1 output-valid; Dop out 1 edge bit; Gradient out 8 magnitude.
REQ-004 SHALL have debug ports: debug_current_state out 2; debug_Out_Row out 8; debug_Out_Column out 8 (centre-pixel coordinates).
REQ-005 SHALL use one clock domain; reset synchronous, active-high (decided).
REQ-006 SHALL process a fixed 256x256, 8-bit grayscale image, streamed one pixel per cycle in raster order (row 0 col 0 first).

Function
REQ-007 SHALL implement states IDLE=0, LOAD=1, COMPUTE=2, DONE=3, visible on debug_current_state.
REQ-008 IDLE: Finish=1; Start=1 sampled at a rising edge -> LOAD next cycle; no pixel sampled on that edge.
REQ-009 SHALL sample DataIn on every rising edge where the current state is LOAD or COMPUTE (until 65536 pixels are taken).
REQ-010 SHALL hold a 3x3 window using two 256-entry line buffers plus window registers; newest pixel = bottom-right of window.
REQ-011 LOAD: on the edge sampling pixel index 514 (row 2, col 2), the first window is complete -> COMPUTE.
REQ-012 COMPUTE: after the edge sampling pixel 65535, stay one flush cycle in COMPUTE (no sample, last window presented), then -> DONE.
REQ-013 DONE: Finish=1; remain while Start=1; Start=0 -> IDLE; no automatic restart.
REQ-014 Finish SHALL be 0 in LOAD and COMPUTE, 1 in IDLE and DONE.
REQ-015 isReady SHALL be 1 only in COMPUTE when the newest-pixel column >= 2 (window does not straddle a row wrap); exactly 254x254 = 64516 valid outputs per frame.
REQ-016 debug_Out_Row/Column SHALL equal the window centre (newest row-1, newest col-1) whenever isReady=1; 0 otherwise.
REQ-017 Gx = (p13 + 2*p23 + p33) - (p11 + 2*p21 + p31); Gy = (p31 + 2*p32 + p33) - (p11 + 2*p12 + p13); pRC = window row R, col C; signed 11-bit arithmetic, no overflow.
REQ-018 Gradient SHALL = min(|Gx| + |Gy|, 255); Dop SHALL = 1 iff Gradient > Threshold (strict, unsigned).
REQ-019 Gradient, Dop, isReady, debug coordinates SHALL be combinational from window/counter registers, valid after the edge capturing the newest pixel, stable until next edge.
REQ-020 When isReady=0, Gradient=0 and Dop=0.
REQ-021 Start changes during LOAD/COMPUTE SHALL be ignored; Threshold may change any cycle and applies immediately.

Reset
REQ-022 RST=1 at a rising edge SHALL force IDLE, clear pixel/row/column counters and window registers, from any state including mid-frame.
REQ-023 After reset: Finish=1, isReady=0, Dop=0, Gradient=0, debug_current_state=0, debug coordinates 0; line buffer contents need not be cleared.
REQ-024 RST SHALL take priority over Start on the same edge.

Verification
REQ-025 Handshake: Start=1 in IDLE -> state 1, Finish=0 next cycle; 515 samples later state 2; after 65536 samples + 1 flush cycle state 3, Finish=1; Start=0 -> state 0.
REQ-026 Uniform image (all 50), Threshold=10 -> 64516 isReady cycles, all Gradient=0, Dop=0; first output centre (1,1), last (254,254).
REQ-027 Vertical step (cols 0-127 = 0, cols 128-255 = 100) -> centre cols 127 and 128: Gradient=255 (400 saturated), Dop=1; all other centres Gradient=0, Dop=0.
REQ-028 Horizontal ramp (pixel = column) -> every output Gradient=8; Threshold=10 -> Dop=0; Threshold=8 -> Dop=0; Threshold=7 -> Dop=1.
REQ-029 Reset mid-COMPUTE (e.g. after 30000 samples) -> next cycle state 0, Finish=1, isReady=0; new Start runs a full frame yielding 64516 outputs.
REQ-030 Row wrap: cycles where newest column is 0 or 1 -> isReady=0, Gradient=0, Dop=0, state remains 2.
